lite_master: RTL and testbench

LITE_MASTER -- requirements
Module: lite_master

---
 rtl/lite_master_if.sv | 33 +++
 rtl/lite_master.sv | 125 ++++++++++++
 tb/tb_lite_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lite_master_if.sv
// lite_master_if: AXI4-Lite write/read channel bundle between lite_master and its slave.
// master modport drives AW/W/AR and B/R ready signals; slave modport is the mirror.
interface lite_master_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
           M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
           M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/lite_master.sv
// lite_master: single-outstanding AXI4-Lite master turning write/read/poll commands into bus transactions.
// Ports: M_AXI_ACLK/M_AXI_ARESETN (async active-low), cmd_* command in (valid/ready),
// rsp_* response out (valid/ready), busy, m = AXI-Lite master channels.
// Define LITE_MASTER_POLL_EN to enable masked read polling bounded by POLL_LIMIT attempts.
module lite_master #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  input  logic        cmd_wr,
  input  logic        cmd_poll,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_mask,
  output logic        cmd_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  lite_master_if.master m
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_t;
  state_t state, state_nxt;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  logic aw_done, w_done;
  logic accept, aw_hs, w_hs, b_hs, r_hs, poll_retry;
  logic unused_ok;
  assign accept = cmd_valid & cmd_ready;
  assign aw_hs = m.M_AXI_AWVALID & m.M_AXI_AWREADY;
  assign w_hs = m.M_AXI_WVALID & m.M_AXI_WREADY;
  assign b_hs = m.M_AXI_BREADY & m.M_AXI_BVALID;
  assign r_hs = m.M_AXI_RREADY & m.M_AXI_RVALID;
  // Every VALID/READY is decoded from registered state only, never from the peer's READY/VALID.
  assign cmd_ready = (state == IDLE) & M_AXI_ARESETN;
  assign busy = state != IDLE;
  assign rsp_valid = state == RSP;
  assign m.M_AXI_AWVALID = (state == WR) & ~aw_done;
  assign m.M_AXI_WVALID = (state == WR) & ~w_done;
  assign m.M_AXI_BREADY = state == WRESP;
  assign m.M_AXI_ARVALID = state == RADDR;
  assign m.M_AXI_RREADY = state == RDATA;
  assign m.M_AXI_AWADDR = addr;
  assign m.M_AXI_ARADDR = addr;
  assign m.M_AXI_WDATA = wdata;
  assign m.M_AXI_WSTRB = wstrb;
`ifdef LITE_MASTER_POLL_EN
  logic [31:0] mask;
  logic poll, timeout, match, poll_miss;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  assign match = ((m.M_AXI_RDATA ^ wdata) & mask) == '0;
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  assign poll_miss = poll & ~m.M_AXI_RRESP[1] & ~match;
  assign poll_retry = poll_miss & (cnt_inc != 17'(POLL_LIMIT));
  assign rsp_timeout = timeout;
  assign unused_ok = ^{m.M_AXI_BRESP[0], m.M_AXI_RRESP[0]};
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      mask <= '0;
      poll <= 1'b0;
      cnt <= '0;
      timeout <= 1'b0;
    end else if (accept) begin
      mask <= cmd_mask;
      poll <= cmd_poll & ~cmd_wr;
      cnt <= '0;
      timeout <= 1'b0;
    end else if (r_hs) begin
      if (poll_retry) cnt <= cnt_inc[15:0];
      timeout <= poll_miss & ~poll_retry;
    end
`else
  assign poll_retry = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_ok = ^{cmd_poll, cmd_mask, m.M_AXI_BRESP[0], m.M_AXI_RRESP[0]};
`endif
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cmd_wr ? WR : RADDR;
      WR:      if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WRESP;
      WRESP:   if (m.M_AXI_BVALID) state_nxt = RSP;
      RADDR:   if (m.M_AXI_ARREADY) state_nxt = RDATA;
      RDATA:   if (m.M_AXI_RVALID) state_nxt = poll_retry ? RADDR : RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        addr <= cmd_addr;
        wdata <= cmd_wdata;
        wstrb <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_err <= m.M_AXI_BRESP[1];
      end
      if (r_hs) begin
        rsp_rdata <= m.M_AXI_RDATA;
        rsp_err <= m.M_AXI_RRESP[1];
      end
    end
endmodule

// File: tb/tb_lite_master.sv
// tb_lite_master: directed self-checking bench for lite_master.
module tb_lite_master;
  localparam int PL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_wr = 1'b0, cmd_poll = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_mask = '0;
  logic [3:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] pvals [8];
  logic [1:0] prr [8];
  int checks = 0;
  int errors = 0;
  lite_master_if bus();
  lite_master #(.POLL_LIMIT(PL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_poll(cmd_poll), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy), .m(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic send_cmd(input logic wr, input logic poll, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] mk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_poll = poll; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_mask = mk;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] br, input logic poll);
    send_cmd(1'b1, poll, a, d, s, '0);
    bus.M_AXI_AWREADY = 1'b1; bus.M_AXI_WREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = br;
    @(negedge clk);
    bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00;
  endtask
  task automatic rd_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr);
    send_cmd(1'b0, 1'b0, a, '0, '0, '0);
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = d; bus.M_AXI_RRESP = rr;
    @(negedge clk);
    bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00;
  endtask
  task automatic rsp_done();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  task automatic run_poll(input logic [31:0] mk, input logic [31:0] wv, output int ars, output bit done);
    int idx = 0;
    ars = 0; done = 1'b0;
    send_cmd(1'b0, 1'b1, 32'h0, wv, 4'h0, mk);
    for (int i = 0; i < 60 && !done; i++) begin
      if (rsp_valid) done = 1'b1;
      else begin
        bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;
        if (bus.M_AXI_ARVALID) ars++;
        bus.M_AXI_RVALID = bus.M_AXI_RREADY;
        if (bus.M_AXI_RREADY) begin
          bus.M_AXI_RDATA = pvals[idx]; bus.M_AXI_RRESP = prr[idx];
          if (idx < 7) idx++;
        end
        @(negedge clk);
      end
    end
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RRESP = 2'b00;
  endtask
  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({busy, rsp_valid, cmd_ready, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
         bus.M_AXI_ARVALID, bus.M_AXI_RREADY} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000000", {busy, rsp_valid, cmd_ready,
        bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
    end
    checks++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== 34'h0) begin
      errors++; $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0", rsp_rdata, rsp_err, rsp_timeout);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_release: cmd_ready,busy got %b want 10", {cmd_ready, busy});
    end
  endtask
  task automatic test_write();
    bus.M_AXI_WREADY = 1'b1;
    send_cmd(1'b1, 1'b0, 32'h0, 32'h2, 4'hF, '0);
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY} !== 3'b110) begin
      errors++; $display("FAIL wr_c1_valids: got %b want 110", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY});
    end
    checks++;
    if ({bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB} !== {32'h0, 32'h2, 4'hF}) begin
      errors++; $display("FAIL wr_c1_payload: got %h %h %h want 0 2 f", bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      bus.M_AXI_WREADY = 1'b0;
      checks++;
      if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_AWADDR} !== {3'b100, 32'h0}) begin
        errors++; $display("FAIL wr_c%0d_awonly: got %b addr %h want 100 addr 0", c,
          {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}, bus.M_AXI_AWADDR);
      end
    end
    bus.M_AXI_AWREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_AWREADY = 1'b0;
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY} !== 3'b001) begin
      errors++; $display("FAIL wr_c5_bready: got %b want 001", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY});
    end
    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = 2'b00;
    @(negedge clk);
    bus.M_AXI_BVALID = 1'b0;
    checks++;
    if ({rsp_valid, busy, cmd_ready, rsp_err, rsp_timeout, rsp_rdata} !== {5'b11000, 32'h0}) begin
      errors++; $display("FAIL wr_rsp: got v%b b%b r%b e%b t%b d%h want v1 b1 r0 e0 t0 d0",
        rsp_valid, busy, cmd_ready, rsp_err, rsp_timeout, rsp_rdata);
    end
    rsp_done();
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL wr_idle: got %b want 001", {rsp_valid, busy, cmd_ready});
    end
  endtask
  task automatic test_read();
    send_cmd(1'b0, 1'b0, 32'h10, '0, '0, '0);
    checks++;
    if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_ARADDR} !== {2'b10, 32'h10}) begin
      errors++; $display("FAIL rd_ar: got %b addr %h want 10 addr 10", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, bus.M_AXI_ARADDR);
    end
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_ARREADY = 1'b0;
    checks++;
    if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY} !== 2'b01) begin
      errors++; $display("FAIL rd_rready: got %b want 01", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
    end
    @(negedge clk);
    bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = 32'hDEADBEEF; bus.M_AXI_RRESP = 2'b00;
    @(negedge clk);
    bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = 32'h0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
        errors++; $display("FAIL rd_hold%0d: got v%b e%b d%h want v1 e0 ddeadbeef", c, rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_done();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_idle: got %b want 01", {rsp_valid, cmd_ready});
    end
  endtask
  task automatic test_error();
    wr_txn(32'h20, 32'h55, 4'hF, 2'b10, 1'b0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL err_wr: got v%b e%b d%h want v1 e1 d0", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_done();
    rd_txn(32'h24, 32'h12345678, 2'b00);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h12345678}) begin
      errors++; $display("FAIL err_rd_ok: got v%b e%b d%h want v1 e0 d12345678", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_done();
    rd_txn(32'h28, 32'hA5, 2'b11);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'hA5}) begin
      errors++; $display("FAIL err_rd_decerr: got v%b e%b d%h want v1 e1 da5", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_done();
  endtask
  task automatic test_write_poll();
    wr_txn(32'h30, 32'h77, 4'h3, 2'b00, 1'b1);
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL wrpoll_rsp: got v%b e%b t%b d%h want v1 e0 t0 d0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    rsp_done();
  endtask
  task automatic test_ignore();
    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_RVALID = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, cmd_ready, bus.M_AXI_BREADY, bus.M_AXI_RREADY, rsp_valid} !== 5'b01000) begin
      errors++; $display("FAIL ign_idle: got %b want 01000", {busy, cmd_ready, bus.M_AXI_BREADY, bus.M_AXI_RREADY, rsp_valid});
    end
    bus.M_AXI_BVALID = 1'b0; bus.M_AXI_RVALID = 1'b0;
    send_cmd(1'b0, 1'b0, 32'h50, '0, '0, '0);
    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = 32'hBAD;
    @(negedge clk);
    checks++;
    if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL ign_raddr: got %b want 100", {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, rsp_valid});
    end
    bus.M_AXI_BVALID = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = 32'h99;
    @(negedge clk);
    bus.M_AXI_RVALID = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h99}) begin
      errors++; $display("FAIL ign_rd_data: got v%b d%h want v1 d99", rsp_valid, rsp_rdata);
    end
    rsp_done();
  endtask
  task automatic test_poll();
    int ars;
    bit done;
    pvals[0] = 32'h4; pvals[1] = 32'h4; pvals[2] = 32'h0;
    for (int i = 0; i < 8; i++) prr[i] = 2'b00;
    for (int i = 3; i < 8; i++) pvals[i] = 32'h4;
    run_poll(32'h4, 32'h0, ars, done);
    checks++;
`ifdef LITE_MASTER_POLL_EN
    if (!done || ars != 3 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL poll_match: done %0d ars %0d d%h t%b want done 1 ars 3 d0 t0", done, ars, rsp_rdata, rsp_timeout);
    end
`else
    if (!done || ars != 1 || rsp_rdata !== 32'h4 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL poll_plain: done %0d ars %0d d%h t%b want done 1 ars 1 d4 t0", done, ars, rsp_rdata, rsp_timeout);
    end
`endif
    rsp_done();
    pvals[2] = 32'h4;
    run_poll(32'h4, 32'h0, ars, done);
    checks++;
`ifdef LITE_MASTER_POLL_EN
    if (!done || ars != PL || rsp_rdata !== 32'h4 || rsp_timeout !== 1'b1) begin
      errors++; $display("FAIL poll_timeout: done %0d ars %0d d%h t%b want done 1 ars 4 d4 t1", done, ars, rsp_rdata, rsp_timeout);
    end
`else
    if (!done || ars != 1 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL poll_no_timeout: done %0d ars %0d t%b want done 1 ars 1 t0", done, ars, rsp_timeout);
    end
`endif
    rsp_done();
    prr[0] = 2'b10;
    run_poll(32'h4, 32'h0, ars, done);
    checks++;
    if (!done || ars != 1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL poll_err: done %0d ars %0d e%b t%b want done 1 ars 1 e1 t0", done, ars, rsp_err, rsp_timeout);
    end
    rsp_done();
  endtask
  task automatic test_reset_mid();
    send_cmd(1'b1, 1'b0, 32'h40, 32'h1, 4'hF, '0);
    bus.M_AXI_AWREADY = 1'b1; bus.M_AXI_WREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
    checks++;
    if ({bus.M_AXI_BREADY, busy} !== 2'b11) begin
      errors++; $display("FAIL rstmid_wresp: got %b want 11", {bus.M_AXI_BREADY, busy});
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, cmd_ready, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
         bus.M_AXI_RREADY, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 42'h0) begin
      errors++; $display("FAIL rstmid_outputs: got b%b c%b bready%b v%b e%b d%h want all 0",
        busy, cmd_ready, bus.M_AXI_BREADY, rsp_valid, rsp_err, rsp_rdata);
    end
    bus.M_AXI_BVALID = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; bus.M_AXI_BVALID = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL rstmid_after: got %b want 001", {rsp_valid, busy, cmd_ready});
    end
    rd_txn(32'h44, 32'hCAFE, 2'b00);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE}) begin
      errors++; $display("FAIL rstmid_read: got v%b e%b d%h want v1 e0 dcafe", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_done();
  endtask
  initial begin
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00;
    bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = 2'b00;
    test_reset();
    test_write();
    test_read();
    test_error();
    test_write_poll();
    test_ignore();
    test_poll();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
